hc05_spi: RTL
=============

# hc05_spi

Register-level model of the 68HC05 slave-controller SPI peripheral, acting as the master side of the `parallelel_spi` byte interface that feeds the servo HLE. CPU writes to SPDR start an 8-bit transfer that lasts as long as the real shifter would. At completion, a single `spi.write` strobe hands the byte to the servo HLE, which answers combinationally on `spi.miso`. The block also implements SPIF/WCOL/MODF status, the SPI interrupt, and the mode-fault path driven by the servo HLE's forced mode-fault output.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `clk_en`  in  1  CPU internal-clock enable; all prescaling counts these
- `sel`  in  1  peripheral selected this cycle (bus access qualifier)
- `addr`  in  2  0=SPCR, 1=SPSR, 2=SPDR, 3=reserved (reads 0xFF, writes ignored)
- `wr`  in  1  write strobe (qualified by `sel`, one `clk` cycle per access)
- `rd`  in  1  read strobe (qualified by `sel`, one `clk` cycle per access)
- `din`  in  8  CPU write data
- `dout`  out  8  CPU read data, combinational from `addr`
- `mode_fault`  in  1  forced mode fault (servo HLE `quirk_force_mode_fault`)
- `irq`  out  1  SPIE & (SPIF | MODF)
- `spi`  modport `parallelel_spi.master`
  - `write`, `mosi` driven by this block.
  - `miso` sampled by this block.

## Operation
- SPCR fields:
  - bit7 SPIE; bit6 SPE; bit4 MSTR; bit3 CPOL; bit2 CPHA; bits1:0 SPR.
  - Bit5 is stored and read back.
  - CPOL/CPHA are stored only and have no effect on timing.
- SPSR fields:
  - bit7 SPIF; bit6 WCOL; bit4 MODF.
  - All other bits read 0.
  - Writes to SPSR are ignored.
- SPDR: the write goes to the shift register; the read returns the receive buffer.
- States:
  - IDLE: SPDR write with SPE=1 and MSTR=1 → load shift register, load prescale counter, go to SHIFT.
    - Any other SPDR write only loads the shift register; no transfer.
  - SHIFT: counts 8×div `clk_en` ticks, div = {2,4,16,32} for SPR = {0,1,2,3}.
    - SPR is sampled at transfer start.
    - When the count expires → DONE.
  - DONE (one `clk` cycle):
    - `spi.write`=1, `spi.mosi`=shift register.
    - `spi.miso` is captured into the receive buffer.
    - Next cycle: SPIF=1, back to IDLE.
- `spi.write` is asserted only in DONE. `spi.mosi` holds the shift register at all times.
- Write collision: an SPDR write in SHIFT or DONE sets WCOL.
  - The ongoing transfer and the shift register are unchanged.
- Flag clearing (status-read arm bit, set by an SPSR read):
  - SPIF and WCOL clear on the first SPDR access (rd or wr) after an SPSR read that saw either flag set.
  - MODF clears on the first SPCR write after an SPSR read that saw MODF set.
  - The arm bit is cleared by the clearing access.
- Mode fault: `mode_fault`=1 in any cycle →
  - MODF=1; SPCR.SPE=0 and SPCR.MSTR=0.
  - Any transfer in SHIFT is aborted to IDLE: no `spi.write`, SPIF unchanged.
- Mode fault in the same cycle as DONE: the DONE strobe still occurs (servo already consumed it); MODF is set alongside.
- Mode fault in the same cycle as an SPCR write: the mode fault wins for SPE/MSTR; the other written bits are taken.

## Timing
- Reset values:
  - SPCR=0x00, SPSR=0x00, shift register and receive buffer=0x00.
  - State IDLE, `spi.write`=0, `irq`=0, `dout`=0x00 for SPCR.
- Latency from SPDR write cycle to `spi.write`: 8×div `clk_en` ticks plus 1 `clk` cycle.
- SPIF and the receive buffer become visible on `dout` the cycle after DONE.
- `irq` is registered from flags; it asserts in the same cycle SPIF/MODF reads as 1.
- A new SPDR write is accepted in the cycle SPIF becomes 1 (state IDLE).
- `clk_en`=0 freezes the prescaler only; bus accesses and mode fault act on every `clk`.
- Async reset mid-transfer: the transfer is lost and no strobe is issued.

## Structure
- Shared package `hc05_spi_pkg`:
  - Register offsets SPCR/SPSR/SPDR.
  - Bit-index constants SPIE/SPE/MSTR/SPIF/WCOL/MODF.
  - The state enum {IDLE, SHIFT, DONE}.
  - The `spr_to_div` function.
- No sub-modules: the prescaler and bit counter are a single 8-bit down-counter loaded with 8×div−1.

## Test plan
- SPCR=0x50, SPR=0; write SPDR=0xB0, servo answers 0x55 → `spi.write` after 16 ticks+1 with mosi=0xB0. SPIF=1; SPDR reads 0x55.
- SPR=3; write 0xAA → strobe exactly 256 ticks+1 later. SPDR write at tick 100 sets WCOL; mosi stays 0xAA.
- SPIF=1: read SPSR (0x80), then read SPDR → SPSR reads 0x00; `irq` drops when SPIE=1.
- `mode_fault` pulse mid-SHIFT → no strobe; SPSR=0x10, SPCR reads 0x00 (from 0x50); `irq`=1 with SPIE. Read SPSR then write SPCR=0x50 → MODF cleared.
- SPE=0; SPDR write 0x12 → no strobe ever; SPIF stays 0.
- Async reset asserted mid-SHIFT → all registers 0x00 immediately; no strobe after release.

Source files
------------

// File: rtl/hc05_spi_pkg.sv
// rtl/hc05_spi_pkg.sv - shared constants, state enum and prescale helpers for hc05_spi
//
// Purpose: register offsets, bit positions, the transfer FSM states and the
// SPR-to-divider mapping used by the SPI register model.
package hc05_spi_pkg;

  // Register offsets on the 2-bit CPU address.
  localparam logic [1:0] ADDR_SPCR = 2'd0;
  localparam logic [1:0] ADDR_SPSR = 2'd1;
  localparam logic [1:0] ADDR_SPDR = 2'd2;

  // SPCR bit positions.
  localparam int BIT_SPIE = 7;
  localparam int BIT_SPE  = 6;
  localparam int BIT_MSTR = 4;

  // SPSR bit positions.
  localparam int BIT_SPIF = 7;
  localparam int BIT_WCOL = 6;
  localparam int BIT_MODF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Shift-clock divider selected by SPR.
  function automatic logic [5:0] spr_to_div(input logic [1:0] spr);
    case (spr)
      2'd0:    return 6'd2;
      2'd1:    return 6'd4;
      2'd2:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Down-counter preload covering all 8 bits: 8*div - 1 (max 255).
  function automatic logic [7:0] spr_to_load(input logic [1:0] spr);
    logic [8:0] w_full;
    w_full = {spr_to_div(spr), 3'b000} - 9'd1;
    return w_full[7:0];
  endfunction

endpackage

// File: rtl/hc05_spi_if.sv
// rtl/hc05_spi_if.sv - byte-wide SPI hand-off interface between hc05_spi and the servo HLE
//
// Purpose: carries one completed transfer per write strobe.
// Signals:
//   write - one-cycle strobe, the byte on mosi is handed over
//   mosi  - shift register contents (held at all times)
//   miso  - servo answer, combinational, sampled during the strobe
interface parallelel_spi;
  logic       write;
  logic [7:0] mosi;
  logic [7:0] miso;

  modport master (output write, output mosi, input miso);
  modport slave  (input write, input mosi, output miso);
endinterface

// File: rtl/hc05_spi.sv
// rtl/hc05_spi.sv - 68HC05 SPI register model driving the parallelel_spi byte interface
//
// Purpose: SPCR/SPSR/SPDR registers, transfer timing from a single prescale
// down-counter, SPIF/WCOL/MODF flags with the status-read clearing sequence,
// and the SPI interrupt.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   clk_en          - CPU clock enable; only the prescaler counts it
//   sel, addr, wr, rd, din, dout - CPU register bus (dout combinational)
//   mode_fault      - forced mode fault from the servo HLE
//   irq             - SPIE & (SPIF | MODF), registered
//   spi             - master side of parallelel_spi
module hc05_spi
  import hc05_spi_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          sel,
  input  logic [1:0]    addr,
  input  logic          wr,
  input  logic          rd,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  input  logic          mode_fault,
  output logic          irq,
  parallelel_spi.master spi
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_spcr;
  logic [7:0] r_shift;
  logic [7:0] r_rxbuf;
  logic [7:0] r_cnt;
  logic       r_spif;
  logic       r_wcol;
  logic       r_modf;
  logic       r_arm_dat;
  logic       r_arm_modf;
  logic       r_irq;

  logic [7:0] w_spcr_nxt;
  logic       w_spif_nxt;
  logic       w_wcol_nxt;
  logic       w_modf_nxt;
  logic       w_arm_dat_nxt;
  logic       w_arm_modf_nxt;

  logic       w_wr_spcr;
  logic       w_rd_spsr;
  logic       w_wr_spdr;
  logic       w_acc_spdr;
  logic       w_start;
  logic       w_cnt_end;

  assign w_wr_spcr  = sel & wr & (addr == ADDR_SPCR);
  assign w_rd_spsr  = sel & rd & (addr == ADDR_SPSR);
  assign w_wr_spdr  = sel & wr & (addr == ADDR_SPDR);
  assign w_acc_spdr = sel & (rd | wr) & (addr == ADDR_SPDR);

  // A mode fault in the start cycle drops SPE/MSTR, so it also blocks the start.
  assign w_start   = (r_state == IDLE) & w_wr_spdr & r_spcr[BIT_SPE] & r_spcr[BIT_MSTR] & ~mode_fault;
  assign w_cnt_end = clk_en & (r_cnt == 8'd0);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and strobe output
  always_comb begin
    w_state_nxt = r_state;
    spi.write   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (mode_fault)     w_state_nxt = IDLE;
        else if (w_cnt_end) w_state_nxt = DONE;
      end
      DONE: begin
        // Strobe survives a coincident mode fault: the servo has already taken the byte.
        spi.write   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign spi.mosi = r_shift;

  // Register and flag next values; later assignments take priority.
  always_comb begin
    w_spcr_nxt     = r_spcr;
    w_spif_nxt     = r_spif;
    w_wcol_nxt     = r_wcol;
    w_modf_nxt     = r_modf;
    w_arm_dat_nxt  = r_arm_dat;
    w_arm_modf_nxt = r_arm_modf;

    if (w_wr_spcr) w_spcr_nxt = din;
    if (mode_fault) begin
      w_spcr_nxt[BIT_SPE]  = 1'b0;
      w_spcr_nxt[BIT_MSTR] = 1'b0;
    end

    // Arm on a status read that saw the flag; the matching access clears.
    if (w_rd_spsr && (r_spif || r_wcol)) w_arm_dat_nxt  = 1'b1;
    if (w_rd_spsr && r_modf)             w_arm_modf_nxt = 1'b1;
    if (w_acc_spdr && r_arm_dat) begin
      w_spif_nxt    = 1'b0;
      w_wcol_nxt    = 1'b0;
      w_arm_dat_nxt = 1'b0;
    end
    if (w_wr_spcr && r_arm_modf) begin
      w_modf_nxt     = 1'b0;
      w_arm_modf_nxt = 1'b0;
    end

    // New events override a clear in the same cycle.
    if (w_wr_spdr && (r_state != IDLE)) w_wcol_nxt = 1'b1;
    if (r_state == DONE)                w_spif_nxt = 1'b1;
    if (mode_fault)                     w_modf_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_spcr     <= 8'h00;
      r_shift    <= 8'h00;
      r_rxbuf    <= 8'h00;
      r_cnt      <= 8'h00;
      r_spif     <= 1'b0;
      r_wcol     <= 1'b0;
      r_modf     <= 1'b0;
      r_arm_dat  <= 1'b0;
      r_arm_modf <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_spcr     <= w_spcr_nxt;
      r_spif     <= w_spif_nxt;
      r_wcol     <= w_wcol_nxt;
      r_modf     <= w_modf_nxt;
      r_arm_dat  <= w_arm_dat_nxt;
      r_arm_modf <= w_arm_modf_nxt;
      // Built from next-state flags so irq rises with the flag it reports.
      r_irq      <= w_spcr_nxt[BIT_SPIE] & (w_spif_nxt | w_modf_nxt);

      // Shift register only accepts CPU data while idle; busy writes are collisions.
      if ((r_state == IDLE) && w_wr_spdr) r_shift <= din;

      if (w_start) begin
        r_cnt <= spr_to_load(r_spcr[1:0]);
      end else if ((r_state == SHIFT) && clk_en && (r_cnt != 8'd0)) begin
        r_cnt <= r_cnt - 8'd1;
      end

      if (r_state == DONE) r_rxbuf <= spi.miso;
    end
  end

  assign irq = r_irq;

  always_comb begin
    dout = 8'hFF;
    case (addr)
      ADDR_SPCR: dout = r_spcr;
      ADDR_SPSR: dout = {r_spif, r_wcol, 1'b0, r_modf, 4'b0000};
      ADDR_SPDR: dout = r_rxbuf;
      default:   dout = 8'hFF;
    endcase
  end

endmodule
